// File: rtl/crc_24_ble_chk.sv
// Receive-side serial CRC-24 checker for the BLE bit path: runs the transmit
// Galois LFSR over payload + CRC field and reports pass/fail and the payload CRC.
module crc_24_ble_chk #(
  parameter logic [63:0] POLYNOM = 64'b1000000000000011001011011,
  parameter logic [23:0] INIT    = 24'h000000,
  parameter int          LEN_W   = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             valid_i,
  input  logic             data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             crc_ok_o,
  output logic [23:0]      crc_o,
  output logic             abort_o
);

  function automatic int poly_width(input logic [63:0] p);
    int w;
    w = 0;
    for (int i = 0; i < 64; i++) begin
      if (p[i]) w = i;
    end
    return w;
  endfunction

  localparam int W     = poly_width(POLYNOM);
  localparam int CNT_W = (LEN_W > $clog2(W + 1)) ? LEN_W : $clog2(W + 1);

  // One bit of the Galois LFSR, identical to the transmit-side generator.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic d);
    logic         fb;
    logic [W-1:0] n;
    fb   = s[W-1] ^ (POLYNOM[0] & d);
    n[0] = fb;
    for (int i = 1; i < W; i++) begin
      n[i] = s[i-1] ^ (POLYNOM[i] & fb);
    end
    return n;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY  = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r, state_s, st_b_s;
  logic [W-1:0]       lfsr_r, lfsr_s, lfsr_b_s, step_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_b_s, cnt_inc_s;
  logic [LEN_W-1:0]   len_r, len_s, len_b_s;
  logic [W-1:0]       crc_r, crc_s;
  logic               ok_r, ok_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               abort_r, abort_s;

  // Next-state: a start pulse first rebases the frame, then the current bit is consumed.
  always_comb begin
    st_b_s   = state_r;
    lfsr_b_s = lfsr_r;
    cnt_b_s  = cnt_r;
    len_b_s  = len_r;
    crc_s    = crc_r;
    ok_s     = ok_r;
    abort_s  = 1'b0;
    done_s   = 1'b0;
    if (start_i) begin
      st_b_s   = (len_i != {LEN_W{1'b0}}) ? ST_PAY : ST_CRC;
      lfsr_b_s = INIT[W-1:0];
      cnt_b_s  = {CNT_W{1'b0}};
      len_b_s  = len_i;
      crc_s    = INIT[W-1:0];
      ok_s     = 1'b0;
      abort_s  = (state_r != ST_IDLE);
    end else if (state_r == ST_DONE) begin
      st_b_s = ST_IDLE;
      ok_s   = (lfsr_r == {W{1'b0}});
      done_s = 1'b1;
    end else begin
      st_b_s = state_r;
    end

    state_s   = st_b_s;
    lfsr_s    = lfsr_b_s;
    cnt_s     = cnt_b_s;
    len_s     = len_b_s;
    cnt_inc_s = cnt_b_s + CNT_W'(1'b1);
    step_s    = lfsr_step(lfsr_b_s, data_i);

    if (valid_i) begin
      case (st_b_s)
        ST_PAY: begin
          lfsr_s = step_s;
          if (cnt_inc_s == CNT_W'(len_b_s)) begin
            crc_s   = step_s;
            state_s = ST_CRC;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        ST_CRC: begin
          lfsr_s = step_s;
          if (cnt_inc_s == CNT_W'(W)) begin
            state_s = ST_DONE;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        default: begin
          cnt_s = cnt_b_s;
        end
      endcase
    end else begin
      cnt_s = cnt_b_s;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      lfsr_r  <= {W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      crc_r   <= {W{1'b0}};
      ok_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_s;
      lfsr_r  <= lfsr_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
      crc_r   <= crc_s;
      ok_r    <= ok_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      abort_r <= abort_s;
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign crc_ok_o = ok_r;
  assign crc_o    = crc_r;
  assign abort_o  = abort_r;

endmodule

// File: tb/tb_crc_24_ble_chk.sv
// Randomized self-checking bench for crc_24_ble_chk; expected CRCs come from
// polynomial long division of payload * x^24 by the generator.
module tb_crc_24_ble_chk;

  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             rst_n_i;
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic             valid_i;
  logic             data_i;
  logic             busy_o;
  logic             done_o;
  logic             crc_ok_o;
  logic [23:0]      crc_o;
  logic             abort_o;

  crc_24_ble_chk #(.LEN_W(LEN_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .len_i   (len_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .crc_ok_o(crc_ok_o),
    .crc_o   (crc_o),
    .abort_o (abort_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic        pay_q[$];
  logic        bits_q[$];
  int          early_done;
  int          abort_cnt;
  logic [2:0]  done_obs;
  logic        obs_ok;
  logic [23:0] obs_crc;

  // Remainder of payload(x) * x^24 modulo G(x), by schoolbook long division.
  function automatic logic [23:0] ref_crc();
    logic [24:0] g;
    logic        m[$];
    logic [23:0] r;
    int          n;
    g = 25'b1000000000000011001011011;
    m = pay_q;
    n = pay_q.size();
    for (int k = 0; k < 24; k++) m.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (m[i]) begin
        for (int k = 0; k < 25; k++) m[i+k] = m[i+k] ^ g[24-k];
      end
    end
    for (int k = 0; k < 24; k++) r[23-k] = m[n+k];
    return r;
  endfunction

  task automatic set_payload(input int len, input bit all_zero);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(all_zero ? 1'b0 : 1'($urandom_range(0, 1)));
  endtask

  task automatic build_bits(input logic [23:0] field);
    bits_q = pay_q;
    for (int k = 23; k >= 0; k--) bits_q.push_back(field[k]);
  endtask

  // Drives one frame from the current negedge; stop_after<0 runs to completion.
  task automatic drive_frame(input bit gaps, input int stop_after);
    int idx;
    int lim;
    int budget;
    idx        = 0;
    budget     = 0;
    lim        = (stop_after < 0) ? bits_q.size() : stop_after;
    early_done = 0;
    abort_cnt  = 0;
    start_i    = 1'b1;
    len_i      = LEN_W'(pay_q.size());
    while (idx < lim && budget < 4000) begin
      if (!gaps || $urandom_range(0, 1) == 1) begin
        valid_i = 1'b1;
        data_i  = bits_q[idx];
        idx++;
      end else begin
        valid_i = 1'b0;
        data_i  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start_i = 1'b0;
      budget++;
      if (done_o) early_done++;
      if (abort_o) abort_cnt++;
    end
    valid_i = 1'b0;
    if (idx < lim) early_done = early_done + 1000;
    if (stop_after < 0) begin
      @(negedge clk);
      done_obs[1] = done_o;
      obs_ok      = crc_ok_o;
      obs_crc     = crc_o;
      @(negedge clk);
      done_obs[0] = done_o;
      done_obs[2] = (early_done != 0);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    start_i = 1'b0;
    len_i   = '0;
    valid_i = 1'b0;
    data_i  = 1'b0;
    #12;
    n_vec++;
    if ({busy_o, done_o, crc_ok_o, abort_o, crc_o} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {busy_o, done_o, crc_ok_o, abort_o, crc_o});
    end
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len0();
    logic [23:0] exp_crc;
    set_payload(0, 1'b1);
    exp_crc = ref_crc();
    build_bits(24'h000000);
    drive_frame(1'b0, -1);
    n_vec++;
    if (done_obs !== 3'b010) begin n_err++; $display("FAIL len0_done: got %b want 010", done_obs); end
    n_vec++;
    if (obs_ok !== 1'b1) begin n_err++; $display("FAIL len0_ok: got %b want 1", obs_ok); end
    n_vec++;
    if (obs_crc !== exp_crc) begin n_err++; $display("FAIL len0_crc: got %h want %h", obs_crc, exp_crc); end
  endtask

  task automatic test_len1(input logic [23:0] field);
    logic [23:0] exp_crc;
    logic        exp_ok;
    pay_q.delete();
    pay_q.push_back(1'b1);
    exp_crc = ref_crc();
    exp_ok  = (field == exp_crc);
    build_bits(field);
    drive_frame(1'b0, -1);
    n_vec++;
    if (done_obs !== 3'b010) begin n_err++; $display("FAIL len1_done: got %b want 010", done_obs); end
    n_vec++;
    if (obs_ok !== exp_ok) begin n_err++; $display("FAIL len1_ok field %h: got %b want %b", field, obs_ok, exp_ok); end
    n_vec++;
    if (obs_crc !== exp_crc) begin n_err++; $display("FAIL len1_crc: got %h want %h", obs_crc, exp_crc); end
  endtask

  task automatic test_gaps();
    logic [23:0] exp_crc;
    set_payload(16, 1'b1);
    exp_crc = ref_crc();
    build_bits(24'h000000);
    drive_frame(1'b1, -1);
    n_vec++;
    if (done_obs !== 3'b010) begin n_err++; $display("FAIL gaps_done: got %b want 010", done_obs); end
    n_vec++;
    if (obs_ok !== 1'b1) begin n_err++; $display("FAIL gaps_ok: got %b want 1", obs_ok); end
    n_vec++;
    if (obs_crc !== exp_crc) begin n_err++; $display("FAIL gaps_crc: got %h want %h", obs_crc, exp_crc); end
  endtask

  task automatic test_random();
    logic [23:0] exp_crc;
    logic [23:0] field;
    logic        exp_ok;
    for (int f = 0; f < 10; f++) begin
      set_payload($urandom_range(0, 48), 1'b0);
      exp_crc = ref_crc();
      field   = exp_crc;
      if ($urandom_range(0, 2) == 0) field[$urandom_range(0, 23)] ^= 1'b1;
      exp_ok = (field == exp_crc);
      build_bits(field);
      drive_frame(1'($urandom_range(0, 1)), -1);
      n_vec++;
      if (done_obs !== 3'b010) begin n_err++; $display("FAIL rand%0d_done: got %b want 010", f, done_obs); end
      n_vec++;
      if (abort_cnt !== 0) begin n_err++; $display("FAIL rand%0d_abort: got %0d want 0", f, abort_cnt); end
      n_vec++;
      if (obs_ok !== exp_ok) begin n_err++; $display("FAIL rand%0d_ok: got %b want %b", f, obs_ok, exp_ok); end
      n_vec++;
      if (obs_crc !== exp_crc) begin n_err++; $display("FAIL rand%0d_crc: got %h want %h", f, obs_crc, exp_crc); end
    end
  endtask

  task automatic test_abort();
    logic [23:0] exp_crc;
    set_payload(16, 1'b0);
    build_bits(ref_crc());
    drive_frame(1'b0, 5);
    n_vec++;
    if (early_done !== 0) begin n_err++; $display("FAIL abort_first_done: got %0d want 0", early_done); end
    pay_q.delete();
    pay_q.push_back(1'b1);
    exp_crc = ref_crc();
    build_bits(exp_crc);
    drive_frame(1'b0, -1);
    n_vec++;
    if (abort_cnt !== 1) begin n_err++; $display("FAIL abort_pulse: got %0d want 1", abort_cnt); end
    n_vec++;
    if (done_obs !== 3'b010) begin n_err++; $display("FAIL abort_done: got %b want 010", done_obs); end
    n_vec++;
    if (obs_ok !== 1'b1) begin n_err++; $display("FAIL abort_ok: got %b want 1", obs_ok); end
  endtask

  task automatic test_async_reset();
    logic [23:0] exp_crc;
    int          late_done;
    set_payload(8, 1'b0);
    pay_q[0] = 1'b1;
    exp_crc  = ref_crc();
    build_bits(exp_crc);
    drive_frame(1'b0, 18);
    n_vec++;
    if ({busy_o, crc_o} !== {1'b1, exp_crc}) begin
      n_err++;
      $display("FAIL arst_before: got %h want %h", {busy_o, crc_o}, {1'b1, exp_crc});
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, crc_ok_o, crc_o} !== 26'h0) begin
      n_err++;
      $display("FAIL arst_clear: got %h want 0", {busy_o, crc_ok_o, crc_o});
    end
    late_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_o) late_done++;
    end
    rst_n_i = 1'b1;
    @(negedge clk);
    if (done_o) late_done++;
    n_vec++;
    if (late_done !== 0) begin n_err++; $display("FAIL arst_no_done: got %0d want 0", late_done); end
    test_len1(24'h00065B);
  endtask

  initial begin
    test_reset();
    test_len0();
    test_len1(24'h00065B);
    test_len1(24'h00065A);
    test_gaps();
    test_random();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
